rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32×64 register file. Two producers compete for the RF's single write port: the execute unit (ALU results) and the memory unit (load data). The block grants the port round-robin, registers the winning write onto the RF write-port signals, and drops writes to XZR (X31). It also keeps a per-register busy bitmap so the issue logic can stall readers of registers with writes still in flight.

## Interface
- NREG, 32, number of architectural registers; register NREG-1 is XZR
- DW, 64, data width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ex_valid  in  1  execute unit has a write pending
- ex_rd  in  5  execute destination register
- ex_data  in  DW  execute result
- ex_ready  out  1  execute write accepted this cycle
- mem_valid  in  1  memory unit has a write pending
- mem_rd  in  5  memory destination register
- mem_data  in  DW  load data
- mem_ready  out  1  memory write accepted this cycle
- claim_valid  in  1  issue logic reserves a destination register
- claim_rd  in  5  register being reserved
- rf_Rd  out  5  RF write address
- rf_data_write  out  DW  RF write data
- rf_reg_wr  out  1  RF write enable
- busy  out  NREG  bit i = 1 while register i has an unretired reserved write

## Operation
- Handshake per requester: valid/ready. A transfer occurs when valid and ready are both 1. ex_ready and mem_ready are combinational from the valids, the rd fields and the priority flop. A requester holds valid, rd and data stable until accepted.
- XZR write (rd == 31): ready = 1 immediately, the write is discarded and does not consume the port. The other requester may be granted in the same cycle.
- Port grant when both requesters have non-XZR writes:
  - the priority flop prio selects the winner (0 = execute, 1 = memory);
  - the loser's ready = 0.
- Port grant when exactly one requester has a non-XZR write: that requester is granted, whatever prio holds.
- Priority update: after any port grant, prio points at the other requester. XZR drops do not change prio.
- Output register: the granted rd and data are loaded into rf_Rd and rf_data_write, with rf_reg_wr = 1, on the next edge. With no grant, rf_reg_wr = 0 and rf_Rd / rf_data_write hold their values.
- Scoreboard:
  - claim_valid with claim_rd ≠ 31 sets busy[claim_rd] on the edge;
  - busy[rf_Rd] clears on the edge where rf_reg_wr = 1, the same edge on which the RF commits the write;
  - if a claim and a clear hit the same register on the same edge, the claim wins and busy stays 1;
  - busy[31] is always 0.
- Writes to a register that is not busy are legal and committed. The scoreboard does not police them.

## Timing
- Reset values: rf_reg_wr = 0, rf_Rd = 0, rf_data_write = 0, busy = 0, prio = 0. No internal state survives reset.
- Reset asserted mid-operation: a write held in the output register is dropped (rf_reg_wr forced to 0 for the next cycle), and ex_ready = mem_ready = 0 while reset is high.
- Accept-to-rf_reg_wr latency: 1 cycle. Accept-to-RF commit and busy clear: 2 edges.
- Throughput: 1 port write per cycle, plus any number of XZR drops in the same cycle.
- Fairness: under continuous contention, grants strictly alternate between the two requesters.

## Structure
- Shared package (rf_pkg):
  - XZR_IDX = 5'd31;
  - NREG, DW defaults;
  - requester-ID enum (REQ_EX = 0, REQ_MEM = 1).
- Sub-module rf_scoreboard: owns the busy bitmap and its set/clear/priority rules.
- The arbiter and output register stay in the top module.

## Test plan
- Reset, then ex_valid = 1, ex_rd = 3, ex_data = 0xAA for one cycle → ex_ready = 1 that cycle; next cycle rf_reg_wr = 1, rf_Rd = 3, rf_data_write = 0xAA; the cycle after, rf_reg_wr = 0.
- Both valid for 4 cycles: ex → X1..X4, mem → X5..X8, holding until accepted → grant order ex, mem, ex, mem, …; each requester waits at most 1 cycle.
- mem_valid with mem_rd = 31 and ex_valid with ex_rd = 7 in the same cycle → both ready = 1; only X7 is written; prio flips once.
- claim_rd = 9, then an ex write to X9 two cycles later → busy[9] = 1 from the claim edge until the edge after rf_reg_wr with rf_Rd = 9.
- claim_rd = 9 asserted on the same edge that X9's write retires → busy[9] stays 1.
- Assert reset on the cycle after a grant → rf_reg_wr = 0 next cycle, busy = 0, and the next contention goes to execute first.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-back path.
package rf_pkg;
    localparam int NREG = 32;
    localparam int DW   = 64;
    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef enum logic {
        REQ_EX  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus: two producers, the issue-side claim port, the RF write port and the busy map.
interface rf_wb_arbiter_if;
    import rf_pkg::*;

    logic            ex_valid;
    logic [4:0]      ex_rd;
    logic [DW-1:0]   ex_data;
    logic            ex_ready;
    logic            mem_valid;
    logic [4:0]      mem_rd;
    logic [DW-1:0]   mem_data;
    logic            mem_ready;
    logic            claim_valid;
    logic [4:0]      claim_rd;
    logic [4:0]      rf_Rd;
    logic [DW-1:0]   rf_data_write;
    logic            rf_reg_wr;
    logic [NREG-1:0] busy;

    modport master (
        output ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data, claim_valid, claim_rd,
        input  ex_ready, mem_ready, rf_Rd, rf_data_write, rf_reg_wr, busy
    );

    modport slave (
        input  ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data, claim_valid, claim_rd,
        output ex_ready, mem_ready, rf_Rd, rf_data_write, rf_reg_wr, busy
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write bitmap: set on claim, cleared when the RF commits, claim beats clear.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            claim_valid,
    input  logic [4:0]      claim_rd,
    input  logic            clr_valid,
    input  logic [4:0]      clr_rd,
    output logic [NREG-1:0] busy
);
    logic [NREG-1:0] busy_next;

    // Clear is applied before set so a same-edge claim on the retiring register keeps it busy.
    always_comb begin
        busy_next = busy;
        if (clr_valid)
            busy_next[clr_rd] = 1'b0;
        if (claim_valid && claim_rd != XZR_IDX)
            busy_next[claim_rd] = 1'b1;
        busy_next[XZR_IDX] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single RF write port with a registered write stage;
// XZR writes are acknowledged and discarded without using the port.
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    rf_wb_arbiter_if.slave bus
);
    req_id_e prio;
    logic    ex_wr;
    logic    mem_wr;
    logic    ex_grant;
    logic    mem_grant;

    always_comb begin
        ex_wr     = bus.ex_valid  && (bus.ex_rd  != XZR_IDX);
        mem_wr    = bus.mem_valid && (bus.mem_rd != XZR_IDX);
        ex_grant  = ex_wr  && (!mem_wr || prio == REQ_EX);
        mem_grant = mem_wr && (!ex_wr  || prio == REQ_MEM);
    end

    assign bus.ex_ready  = !reset && bus.ex_valid  && ((bus.ex_rd  == XZR_IDX) || ex_grant);
    assign bus.mem_ready = !reset && bus.mem_valid && ((bus.mem_rd == XZR_IDX) || mem_grant);

    // Address and data hold when idle; only the enable drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rf_reg_wr     <= 1'b0;
            bus.rf_Rd         <= '0;
            bus.rf_data_write <= '0;
            prio              <= REQ_EX;
        end else if (ex_grant) begin
            bus.rf_reg_wr     <= 1'b1;
            bus.rf_Rd         <= bus.ex_rd;
            bus.rf_data_write <= bus.ex_data;
            prio              <= REQ_MEM;
        end else if (mem_grant) begin
            bus.rf_reg_wr     <= 1'b1;
            bus.rf_Rd         <= bus.mem_rd;
            bus.rf_data_write <= bus.mem_data;
            prio              <= REQ_EX;
        end else begin
            bus.rf_reg_wr     <= 1'b0;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .claim_valid (bus.claim_valid),
        .claim_rd    (bus.claim_rd),
        .clr_valid   (bus.rf_reg_wr),
        .clr_rd      (bus.rf_Rd),
        .busy        (bus.busy)
    );
endmodule
